// File: rtl/rv32m_divider.sv
// rtl/rv32m_divider.sv - RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per clock
module rv32m_divider (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        FLUSH,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] DATA1,
   input  logic [31:0] DATA2,
   input  logic [4:0]  RD_IN,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] RESULT,
   output logic [4:0]  RD_OUT
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, state_next;
   logic        op_signed, op_rem, sign_a, sign_b, special;
   logic [4:0]  rd_lat;
   logic [4:0]  count;
   logic [32:0] rem;
   logic [31:0] quo;
   logic [31:0] dvsr;

   logic        in_signed, in_rem, div_zero, overflow, accept;
   logic [31:0] abs_a, abs_b;
   logic [33:0] rem_sh, diff;
   logic [31:0] q_fix, r_fix;

   // Codes other than DIV/REM/REMU decode to DIVU.
   assign in_signed = (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
   assign in_rem    = (FUNCT3 == 3'b110) || (FUNCT3 == 3'b111);
   assign abs_a     = (in_signed && DATA1[31]) ? (32'd0 - DATA1) : DATA1;
   assign abs_b     = (in_signed && DATA2[31]) ? (32'd0 - DATA2) : DATA2;
   assign div_zero  = (DATA2 == 32'd0);
   assign overflow  = in_signed && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
   assign accept    = (state == IDLE) && START && !FLUSH;

   // Remainder stays below the divisor, so the shifted value fits 33 bits; bit 33 is the borrow.
   assign rem_sh = {rem, quo[31]};
   assign diff   = rem_sh - {2'b00, dvsr};

   assign q_fix = (!special && op_signed && (sign_a ^ sign_b)) ? (32'd0 - quo) : quo;
   assign r_fix = (!special && op_signed && sign_a) ? (32'd0 - rem[31:0]) : rem[31:0];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (START) state_next = (div_zero || overflow) ? FIX : CALC;
         CALC:    if (count == 5'd31) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (FLUSH) state_next = IDLE;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         op_signed <= 1'b0;
         op_rem    <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         special   <= 1'b0;
         rd_lat    <= 5'd0;
         count     <= 5'd0;
         rem       <= 33'd0;
         quo       <= 32'd0;
         dvsr      <= 32'd0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         RESULT    <= 32'd0;
         RD_OUT    <= 5'd0;
      end else begin
         BUSY <= (state_next != IDLE);
         DONE <= (state == FIX) && !FLUSH;
         if (accept) begin
            op_signed <= in_signed;
            op_rem    <= in_rem;
            sign_a    <= in_signed && DATA1[31];
            sign_b    <= in_signed && DATA2[31];
            rd_lat    <= RD_IN;
            count     <= 5'd0;
            dvsr      <= abs_b;
            special   <= div_zero || overflow;
            if (div_zero) begin
               quo <= 32'hFFFF_FFFF;
               rem <= {1'b0, DATA1};
            end else if (overflow) begin
               quo <= 32'h8000_0000;
               rem <= 33'd0;
            end else begin
               quo <= abs_a;
               rem <= 33'd0;
            end
         end else if (state == CALC && !FLUSH) begin
            count <= count + 5'd1;
            if (!diff[33]) begin
               rem <= diff[32:0];
               quo <= {quo[30:0], 1'b1};
            end else begin
               rem <= rem_sh[32:0];
               quo <= {quo[30:0], 1'b0};
            end
         end else if (state == FIX && !FLUSH) begin
            RESULT <= op_rem ? r_fix : q_fix;
            RD_OUT <= rd_lat;
         end
      end
   end

endmodule

// File: tb/tb_rv32m_divider.sv
// tb/tb_rv32m_divider.sv - directed vector bench for rv32m_divider
module tb_rv32m_divider;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        START = 1'b0;
   logic        FLUSH = 1'b0;
   logic [2:0]  FUNCT3 = 3'd0;
   logic [31:0] DATA1 = 32'd0;
   logic [31:0] DATA2 = 32'd0;
   logic [4:0]  RD_IN = 5'd0;
   logic        BUSY, DONE;
   logic [31:0] RESULT;
   logic [4:0]  RD_OUT;

   int n_vec = 0;
   int n_bad = 0;

   rv32m_divider dut (
      .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH), .FUNCT3(FUNCT3),
      .DATA1(DATA1), .DATA2(DATA2), .RD_IN(RD_IN), .BUSY(BUSY), .DONE(DONE),
      .RESULT(RESULT), .RD_OUT(RD_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic st, input logic fl);
      @(negedge CLK);
      START = st; FLUSH = fl; FUNCT3 = f3; DATA1 = a; DATA2 = b; RD_IN = rd;
      @(posedge CLK);
      #1;
      START = 1'b0; FLUSH = 1'b0;
      FUNCT3 = 3'b100; DATA1 = 32'hDEAD_BEEF; DATA2 = 32'h0000_0003; RD_IN = 5'd31;
   endtask

   // Counts edges after the START edge until DONE; `pre` edges have already elapsed.
   task automatic wait_done(input string name, input int pre, input int exp_lat,
                            input logic [31:0] exp_res, input logic [4:0] exp_rd);
      int  edges = pre;
      logic busy_ok = 1'b1;
      while (!DONE && edges < 100) begin
         if (!BUSY) busy_ok = 1'b0;
         @(posedge CLK);
         #1;
         edges++;
      end
      check({name, " latency"}, edges, exp_lat);
      check({name, " result"}, RESULT, exp_res);
      check({name, " rd"}, {27'd0, RD_OUT}, {27'd0, exp_rd});
      check({name, " busy_with_done"}, {31'd0, BUSY}, 32'd0);
      check({name, " busy_while_running"}, {31'd0, busy_ok}, 32'd1);
   endtask

   task automatic expect_no_done(input string name, input int cycles);
      logic seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge CLK);
         #1;
         if (DONE || BUSY) seen = 1'b1;
      end
      check({name, " no_done"}, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{3'b101, 32'd100,        32'd7,          5'd5,  32'h0000_000E, 33};
      vecs[1]  = '{3'b111, 32'd100,        32'd7,          5'd6,  32'h0000_0002, 33};
      vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD, 33};
      vecs[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF, 33};
      vecs[4]  = '{3'b110, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'h0000_0001, 33};
      vecs[5]  = '{3'b100, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF, 1};
      vecs[6]  = '{3'b111, 32'd5,          32'd0,          5'd11, 32'h0000_0005, 1};
      vecs[7]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000, 1};
      vecs[8]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h0000_0000, 1};
      vecs[9]  = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h0000_0000, 33};
      vecs[10] = '{3'b111, 32'hFFFF_FFFF,  32'd10,         5'd15, 32'h0000_0005, 33};
      vecs[11] = '{3'b000, 32'd50,         32'd5,          5'd16, 32'h0000_000A, 33};
      vecs[12] = '{3'b110, 32'hFFFF_FFF9,  32'd0,          5'd17, 32'hFFFF_FFF9, 1};
      vecs[13] = '{3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd18, 32'h0000_000E, 33};

      #12;
      check("reset busy", {31'd0, BUSY}, 32'd0);
      check("reset done", {31'd0, DONE}, 32'd0);
      check("reset result", RESULT, 32'd0);
      check("reset rd", {27'd0, RD_OUT}, 32'd0);
      @(negedge CLK);
      RESET = 1'b1;

      foreach (vecs[i]) begin
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, 1'b0);
         wait_done($sformatf("vec%0d", i), 0, vecs[i].exp_lat, vecs[i].exp_res, vecs[i].rd);
      end

      // START while busy is ignored; then back-to-back issue in the DONE cycle.
      issue(3'b101, 32'd1000, 32'd10, 5'd3, 1'b1, 1'b0);
      repeat (9) begin
         @(posedge CLK);
         #1;
      end
      issue(3'b100, 32'd7, 32'd0, 5'd9, 1'b1, 1'b0);
      wait_done("ignored_start", 10, 33, 32'd100, 5'd3);
      check("dup done high", {31'd0, DONE}, 32'd1);
      issue(3'b101, 32'd9, 32'd3, 5'd4, 1'b1, 1'b0);
      check("b2b busy", {31'd0, BUSY}, 32'd1);
      check("b2b done fell", {31'd0, DONE}, 32'd0);
      check("b2b result held", RESULT, 32'd100);
      wait_done("b2b", 0, 33, 32'd3, 5'd4);

      // FLUSH at edge k+15.
      issue(3'b111, 32'd100, 32'd7, 5'd7, 1'b1, 1'b0);
      repeat (14) begin
         @(posedge CLK);
         #1;
      end
      issue(3'b000, 32'd0, 32'd1, 5'd0, 1'b0, 1'b1);
      check("flush busy", {31'd0, BUSY}, 32'd0);
      expect_no_done("flush", 40);
      check("flush result held", RESULT, 32'd3);
      check("flush rd held", {27'd0, RD_OUT}, 32'd4);

      // FLUSH and START on the same edge.
      issue(3'b101, 32'd100, 32'd7, 5'd7, 1'b1, 1'b1);
      check("flush_start busy", {31'd0, BUSY}, 32'd0);
      expect_no_done("flush_start", 40);

      // Asynchronous reset mid-CALC, between edges.
      issue(3'b101, 32'd100, 32'd7, 5'd5, 1'b1, 1'b0);
      repeat (10) begin
         @(posedge CLK);
         #1;
      end
      @(negedge CLK);
      #2;
      RESET = 1'b0;
      #1;
      check("async busy", {31'd0, BUSY}, 32'd0);
      check("async done", {31'd0, DONE}, 32'd0);
      check("async result", RESULT, 32'd0);
      check("async rd", {27'd0, RD_OUT}, 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      issue(3'b101, 32'd9, 32'd3, 5'd8, 1'b1, 1'b0);
      wait_done("post_reset", 0, 33, 32'd3, 5'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
